spi_target: RTL and testbench



---
 rtl/spi_target_pkg.sv | 31 +++
 rtl/spi_target_sync.sv | 39 +++
 rtl/spi_target.sv | 180 ++++++++++++++++++
 tb/tb_spi_target.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared register map, bit positions and constants for the SPI target peripheral.
package spi_target_pkg;

    localparam logic [11:0] ADDR_CONFIG = 12'h000;
    localparam logic [11:0] ADDR_STATUS = 12'h004;
    localparam logic [11:0] ADDR_DATA   = 12'h008;

    localparam int CFG_CPHA           = 0;
    localparam int CFG_CPOL           = 1;
    localparam int CFG_MSB_FIRST      = 2;
    localparam int CFG_ACTIVE_HIGH_CS = 3;
    localparam int CFG_ENABLE         = 4;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_OVERRUN  = 2;
    localparam int STAT_SELECTED = 3;

    localparam logic [7:0] CONFIG_DEFAULT = 8'h04;
    localparam logic [7:0] TX_FILL        = 8'hFF;

    // Field order matches the config register bit positions (enable is bit 4).
    typedef struct packed {
        logic enable;
        logic active_high_cs;
        logic msb_first;
        logic cpol;
        logic cpha;
    } cfg_t;

endpackage

// File: rtl/spi_target_sync.sv
// Synchronizes the external SCK/CS/MOSI into clk and flags SCK edges.
module spi_target_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sck,
    input  logic i_cs,
    input  logic i_mosi,
    output logic o_cs,
    output logic o_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall
);
    logic [SYNC_STAGES-1:0] r_sck_q;
    logic [SYNC_STAGES-1:0] r_cs_q;
    logic [SYNC_STAGES-1:0] r_mosi_q;
    logic                   r_sck_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_q    <= '0;
            r_cs_q     <= '0;
            r_mosi_q   <= '0;
            r_sck_prev <= 1'b0;
        end else begin
            r_sck_q    <= {r_sck_q[SYNC_STAGES-2:0], i_sck};
            r_cs_q     <= {r_cs_q[SYNC_STAGES-2:0], i_cs};
            r_mosi_q   <= {r_mosi_q[SYNC_STAGES-2:0], i_mosi};
            r_sck_prev <= r_sck_q[SYNC_STAGES-1];
        end
    end

    assign o_cs       = r_cs_q[SYNC_STAGES-1];
    assign o_mosi     = r_mosi_q[SYNC_STAGES-1];
    assign o_sck_rise = r_sck_q[SYNC_STAGES-1] & ~r_sck_prev;
    assign o_sck_fall = ~r_sck_q[SYNC_STAGES-1] & r_sck_prev;

endmodule

// File: rtl/spi_target.sv
// SPI target peripheral: oversampled SPI link, one byte per transfer, three bus registers.
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [3:0] ID          = 4'h0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        peripheralEnable,
    input  logic        peripheralBus_we,
    input  logic        peripheralBus_oe,
    output logic        peripheralBus_busy,
    input  logic [15:0] peripheralBus_address,
    input  logic [3:0]  peripheralBus_byteSelect,
    output logic [31:0] peripheralBus_dataRead,
    input  logic [31:0] peripheralBus_dataWrite,
    output logic        requestOutput,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        spi_cs,
    output logic        spi_miso,
    output logic        spi_miso_en
);
    cfg_t       r_cfg;
    logic       r_rx_valid;
    logic       r_tx_empty;
    logic       r_overrun;
    logic [7:0] r_rx_buf;
    logic [7:0] r_tx_buf;
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [2:0] r_bit_cnt;
    logic       r_skip;
    logic       r_sel_prev;
    logic       r_miso;

    logic       w_cs_s;
    logic       w_mosi_s;
    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_selected;
    logic       w_sample_edge;
    logic       w_shift_edge;
    logic [7:0] w_rx_next;
    logic [7:0] w_reload;
    logic       w_dev_sel;
    logic [11:0] w_offset;
    logic       w_wr;
    logic       w_rd;
    logic       w_wr_cfg;
    logic       w_wr_status;
    logic       w_wr_data;
    logic       w_rd_data;
    logic [7:0] w_status;
    logic [7:0] w_rd_byte;
    logic       w_unused;

    spi_target_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_sck      (spi_clk),
        .i_cs       (spi_cs),
        .i_mosi     (spi_mosi),
        .o_cs       (w_cs_s),
        .o_mosi     (w_mosi_s),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall)
    );

    assign w_selected    = r_cfg.enable && (w_cs_s == r_cfg.active_high_cs);
    assign w_sample_edge = (r_cfg.cpol == r_cfg.cpha) ? w_sck_rise : w_sck_fall;
    assign w_shift_edge  = (r_cfg.cpol == r_cfg.cpha) ? w_sck_fall : w_sck_rise;
    assign w_rx_next     = r_cfg.msb_first ? {r_rx_shift[6:0], w_mosi_s}
                                           : {w_mosi_s, r_rx_shift[7:1]};
    assign w_reload      = r_tx_empty ? TX_FILL : r_tx_buf;

    assign w_dev_sel   = peripheralEnable && (peripheralBus_address[15:12] == ID);
    assign w_offset    = peripheralBus_address[11:0];
    assign w_wr        = w_dev_sel && peripheralBus_we && peripheralBus_byteSelect[0];
    assign w_rd        = w_dev_sel && peripheralBus_oe;
    assign w_wr_cfg    = w_wr && (w_offset == ADDR_CONFIG);
    assign w_wr_status = w_wr && (w_offset == ADDR_STATUS);
    assign w_wr_data   = w_wr && (w_offset == ADDR_DATA);
    assign w_rd_data   = w_rd && (w_offset == ADDR_DATA);

    always_comb begin
        w_status                = 8'h00;
        w_status[STAT_RX_VALID] = r_rx_valid;
        w_status[STAT_TX_EMPTY] = r_tx_empty;
        w_status[STAT_OVERRUN]  = r_overrun;
        w_status[STAT_SELECTED] = w_selected;
        w_rd_byte               = 8'h00;
        case (w_offset)
            ADDR_CONFIG: w_rd_byte = {3'b000, r_cfg};
            ADDR_STATUS: w_rd_byte = w_status;
            ADDR_DATA:   w_rd_byte = r_rx_buf;
            default:     w_rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg      <= cfg_t'(CONFIG_DEFAULT[4:0]);
            r_rx_valid <= 1'b0;
            r_tx_empty <= 1'b1;
            r_overrun  <= 1'b0;
            r_rx_buf   <= 8'h00;
            r_tx_buf   <= 8'h00;
            r_rx_shift <= 8'h00;
            r_tx_shift <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_skip     <= 1'b0;
            r_sel_prev <= 1'b0;
            r_miso     <= 1'b0;
        end else begin
            r_sel_prev <= w_selected;
            r_miso     <= r_cfg.msb_first ? r_tx_shift[7] : r_tx_shift[0];

            if (w_rd_data)
                r_rx_valid <= 1'b0;
            if (w_wr_status && peripheralBus_dataWrite[STAT_OVERRUN])
                r_overrun <= 1'b0;

            if (!w_selected) begin
                r_bit_cnt <= 3'd0;
            end else if (!r_sel_prev) begin
                r_bit_cnt  <= 3'd0;
                r_tx_shift <= w_reload;
                r_tx_empty <= 1'b1;
                r_skip     <= r_cfg.cpha;
            end else if (w_sample_edge) begin
                r_rx_shift <= w_rx_next;
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    // A read in this same cycle frees the buffer for the new byte.
                    if (!r_rx_valid || w_rd_data) begin
                        r_rx_buf   <= w_rx_next;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                    r_tx_shift <= w_reload;
                    r_tx_empty <= 1'b1;
                    r_skip     <= 1'b1;
                end
            end else if (w_shift_edge) begin
                if (r_skip)
                    r_skip <= 1'b0;
                else if (r_cfg.msb_first)
                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                else
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end

            if (w_wr_cfg)
                r_cfg <= '{enable:         peripheralBus_dataWrite[CFG_ENABLE],
                           active_high_cs: peripheralBus_dataWrite[CFG_ACTIVE_HIGH_CS],
                           msb_first:      peripheralBus_dataWrite[CFG_MSB_FIRST],
                           cpol:           peripheralBus_dataWrite[CFG_CPOL],
                           cpha:           peripheralBus_dataWrite[CFG_CPHA]};
            // Bus write lands after any reload so txEmpty ends up cleared.
            if (w_wr_data) begin
                r_tx_buf   <= peripheralBus_dataWrite[7:0];
                r_tx_empty <= 1'b0;
            end
        end
    end

    assign peripheralBus_busy     = 1'b0;
    assign requestOutput          = w_rd;
    assign peripheralBus_dataRead = w_rd ? {24'h000000, w_rd_byte} : 32'hFFFF_FFFF;
    assign spi_miso               = r_miso;
    assign spi_miso_en            = w_selected;

    assign w_unused = ^{peripheralBus_byteSelect[3:1], peripheralBus_dataWrite[31:8]};

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: drives an SPI controller model and the register bus.
module tb_spi_target;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        peripheralEnable = 1'b0;
    logic        peripheralBus_we = 1'b0;
    logic        peripheralBus_oe = 1'b0;
    logic        peripheralBus_busy;
    logic [15:0] peripheralBus_address = 16'h0000;
    logic [3:0]  peripheralBus_byteSelect = 4'h0;
    logic [31:0] peripheralBus_dataRead;
    logic [31:0] peripheralBus_dataWrite = 32'h0;
    logic        requestOutput;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_miso;
    logic        spi_miso_en;

    int checks = 0;
    int failures = 0;
    logic cpol = 1'b0, cpha = 1'b0, msb = 1'b1;
    logic [31:0] rd;
    logic [7:0]  seq;

    spi_target dut (
        .clk                      (clk),
        .rst                      (rst),
        .peripheralEnable         (peripheralEnable),
        .peripheralBus_we         (peripheralBus_we),
        .peripheralBus_oe         (peripheralBus_oe),
        .peripheralBus_busy       (peripheralBus_busy),
        .peripheralBus_address    (peripheralBus_address),
        .peripheralBus_byteSelect (peripheralBus_byteSelect),
        .peripheralBus_dataRead   (peripheralBus_dataRead),
        .peripheralBus_dataWrite  (peripheralBus_dataWrite),
        .requestOutput            (requestOutput),
        .spi_clk                  (spi_clk),
        .spi_mosi                 (spi_mosi),
        .spi_cs                   (spi_cs),
        .spi_miso                 (spi_miso),
        .spi_miso_en              (spi_miso_en)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] off, input logic [31:0] d);
        peripheralEnable         = 1'b1;
        peripheralBus_we         = 1'b1;
        peripheralBus_address    = {4'h0, off};
        peripheralBus_byteSelect = 4'h1;
        peripheralBus_dataWrite  = d;
        tick(1);
        peripheralEnable         = 1'b0;
        peripheralBus_we         = 1'b0;
        peripheralBus_byteSelect = 4'h0;
    endtask

    task automatic bus_read(input logic [11:0] off, output logic [31:0] d);
        peripheralEnable      = 1'b1;
        peripheralBus_oe      = 1'b1;
        peripheralBus_address = {4'h0, off};
        #1;
        d = peripheralBus_dataRead;
        @(posedge clk);
        #1;
        peripheralEnable = 1'b0;
        peripheralBus_oe = 1'b0;
    endtask

    // Controller side: sends n bits of d, returns MISO bits in time order (first bit at [7]).
    task automatic xfer(input int n, input logic [7:0] d, output logic [7:0] s);
        s = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (!cpha) begin
                spi_mosi = msb ? d[7-i] : d[i];
                tick(H);
                s[7-i]  = spi_miso;
                spi_clk = ~cpol;
                tick(H);
                spi_clk = cpol;
            end else begin
                spi_clk  = ~cpol;
                spi_mosi = msb ? d[7-i] : d[i];
                tick(H);
                s[7-i]  = spi_miso;
                spi_clk = cpol;
                tick(H);
            end
        end
        tick(H);
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(4);

        // Reset state
        check("rst_miso", {31'b0, spi_miso}, 32'h0);
        check("rst_miso_en", {31'b0, spi_miso_en}, 32'h0);
        check("idle_rdata", peripheralBus_dataRead, 32'hFFFF_FFFF);
        bus_read(12'h000, rd); check("rst_config", rd, 32'h04);
        bus_read(12'h004, rd); check("rst_status", rd, 32'h02);
        bus_read(12'h008, rd); check("rst_data", rd, 32'h00);

        // Mode 0, MSB first
        bus_write(12'h008, 32'hA5);
        bus_write(12'h000, 32'h14);
        spi_cs = 1'b0;
        tick(H);
        check("m0_miso_en", {31'b0, spi_miso_en}, 32'h1);
        xfer(8, 8'h3C, seq);
        spi_cs = 1'b1;
        tick(H);
        check("m0_miso_seq", {24'b0, seq}, 32'hA5);
        bus_read(12'h004, rd); check("m0_status", rd, 32'h03);
        bus_read(12'h008, rd); check("m0_rxbuf", rd, 32'h3C);
        bus_read(12'h004, rd); check("m0_status_after_read", rd, 32'h02);

        // Mode 3, LSB first
        cpol = 1'b1; cpha = 1'b1; msb = 1'b0;
        spi_clk = 1'b1;
        tick(4);
        bus_write(12'h008, 32'h81);
        bus_write(12'h000, 32'h13);
        spi_cs = 1'b0;
        tick(H);
        xfer(8, 8'h5A, seq);
        spi_cs = 1'b1;
        tick(H);
        check("m3_miso_seq", {24'b0, seq}, 32'h81);
        bus_read(12'h008, rd); check("m3_rxbuf", rd, 32'h5A);

        // Back to mode 0: two bytes in one frame, txBuf underrun and overrun
        cpol = 1'b0; cpha = 1'b0; msb = 1'b1;
        spi_clk = 1'b0;
        tick(4);
        bus_write(12'h000, 32'h14);
        bus_write(12'h008, 32'h5A);
        spi_cs = 1'b0;
        tick(H);
        xfer(8, 8'h11, seq);
        check("b2b_miso1", {24'b0, seq}, 32'h5A);
        xfer(8, 8'h22, seq);
        check("b2b_miso2", {24'b0, seq}, 32'hFF);
        spi_cs = 1'b1;
        tick(H);
        bus_read(12'h004, rd); check("b2b_status", rd, 32'h07);
        bus_write(12'h004, 32'h04);
        bus_read(12'h004, rd); check("w1c_status", rd, 32'h03);
        bus_read(12'h008, rd); check("b2b_rxbuf", rd, 32'h11);

        // Partial byte, deselect, then a full byte
        spi_cs = 1'b0;
        tick(H);
        xfer(5, 8'hE7, seq);
        spi_cs = 1'b1;
        tick(H);
        check("part_miso_en", {31'b0, spi_miso_en}, 32'h0);
        bus_read(12'h004, rd); check("part_status", rd, 32'h02);
        spi_cs = 1'b0;
        tick(H);
        xfer(8, 8'hC3, seq);
        spi_cs = 1'b1;
        tick(H);
        bus_read(12'h004, rd); check("full_status", rd, 32'h03);

        // Data read in the same cycle as byte completion (rxValid already 1)
        spi_cs = 1'b0;
        tick(H);
        xfer(7, 8'h96, seq);
        spi_mosi = 1'b0;
        tick(H);
        spi_clk = 1'b1;
        tick(2);
        peripheralEnable      = 1'b1;
        peripheralBus_oe      = 1'b1;
        peripheralBus_address = 16'h0008;
        #1;
        check("race_old_rxbuf", peripheralBus_dataRead, 32'hC3);
        check("race_request", {31'b0, requestOutput}, 32'h1);
        @(posedge clk);
        #1;
        peripheralEnable = 1'b0;
        peripheralBus_oe = 1'b0;
        tick(5);
        spi_clk = 1'b0;
        tick(H);
        spi_cs = 1'b1;
        tick(H);
        bus_read(12'h004, rd); check("race_status", rd, 32'h03);
        bus_read(12'h008, rd); check("race_rxbuf", rd, 32'h96);

        // Reset mid-transfer
        bus_write(12'h008, 32'h7E);
        spi_cs = 1'b0;
        tick(H);
        xfer(3, 8'hFF, seq);
        rst = 1'b1;
        tick(2);
        check("midrst_miso", {31'b0, spi_miso}, 32'h0);
        check("midrst_miso_en", {31'b0, spi_miso_en}, 32'h0);
        check("midrst_request", {31'b0, requestOutput}, 32'h0);
        rst = 1'b0;
        tick(1);
        bus_read(12'h000, rd); check("midrst_config", rd, 32'h04);
        bus_read(12'h004, rd); check("midrst_status", rd, 32'h02);
        bus_read(12'h008, rd); check("midrst_rxbuf", rd, 32'h00);
        spi_cs = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
